// File: rtl/alu_issue_receiver.sv
// alu_issue_receiver: FU-side endpoint of the ALU issue/writeback handshake.
// Optional one-entry issue skid buffer: `define ALU_RECV_SKID_EN.
module alu_issue_receiver #(
  parameter int WF_ID_LENGTH = 6,
  parameter int OPCODE_WIDTH = 32,
  parameter int LATENCY      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_select,
  input  logic [WF_ID_LENGTH-1:0] issue_wfid,
  input  logic [OPCODE_WIDTH-1:0] issue_opcode,
  output logic                    fu_ready,
  output logic [WF_ID_LENGTH-1:0] busy_wfid,
  output logic                    wb_valid,
  output logic [WF_ID_LENGTH-1:0] wb_wfid,
  output logic [OPCODE_WIDTH-1:0] wb_opcode,
  input  logic                    wb_ack,
  output logic                    protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              cnt;
  logic [7:0]              cnt_nxt;
  logic                    ready_nxt;
  logic                    valid_nxt;
  logic                    err_nxt;
  logic [WF_ID_LENGTH-1:0] wfid_nxt;
  logic [WF_ID_LENGTH-1:0] busy_nxt;
  logic [OPCODE_WIDTH-1:0] opcode_nxt;

  logic accept;
  logic violation;
  logic ack;

  assign accept    = issue_select && fu_ready;
  assign violation = issue_select && !fu_ready;
  assign ack       = wb_ack && wb_valid;

`ifdef ALU_RECV_SKID_EN
  logic                    skid_full;
  logic                    skid_full_nxt;
  logic [WF_ID_LENGTH-1:0] skid_wfid;
  logic [WF_ID_LENGTH-1:0] skid_wfid_nxt;
  logic [OPCODE_WIDTH-1:0] skid_opcode;
  logic [OPCODE_WIDTH-1:0] skid_opcode_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready_nxt  = fu_ready;
    valid_nxt  = wb_valid;
    wfid_nxt   = wb_wfid;
    opcode_nxt = wb_opcode;
    busy_nxt   = busy_wfid;
    err_nxt    = protocol_err | violation;
`ifdef ALU_RECV_SKID_EN
    skid_full_nxt   = skid_full;
    skid_wfid_nxt   = skid_wfid;
    skid_opcode_nxt = skid_opcode;
`endif
    unique case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          wfid_nxt   = issue_wfid;
          opcode_nxt = issue_opcode;
          busy_nxt   = issue_wfid;
          cnt_nxt    = CNT_INIT;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 8'd0) begin
          state_nxt = WB;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
`ifdef ALU_RECV_SKID_EN
        if (accept) begin
          skid_full_nxt   = 1'b1;
          skid_wfid_nxt   = issue_wfid;
          skid_opcode_nxt = issue_opcode;
        end
`endif
      end
      WB: begin
`ifdef ALU_RECV_SKID_EN
        if (ack) begin
          valid_nxt = 1'b0;
          if (skid_full) begin
            // drain skid into execution; a same-edge issue refills it
            wfid_nxt        = skid_wfid;
            opcode_nxt      = skid_opcode;
            busy_nxt        = skid_wfid;
            cnt_nxt         = CNT_INIT;
            state_nxt       = EXEC;
            skid_full_nxt   = accept;
            if (accept) begin
              skid_wfid_nxt   = issue_wfid;
              skid_opcode_nxt = issue_opcode;
            end
          end else if (accept) begin
            wfid_nxt   = issue_wfid;
            opcode_nxt = issue_opcode;
            busy_nxt   = issue_wfid;
            cnt_nxt    = CNT_INIT;
            state_nxt  = EXEC;
          end else begin
            busy_nxt  = '0;
            state_nxt = IDLE;
          end
        end else if (accept) begin
          skid_full_nxt   = 1'b1;
          skid_wfid_nxt   = issue_wfid;
          skid_opcode_nxt = issue_opcode;
        end
`else
        if (ack) begin
          valid_nxt = 1'b0;
          busy_nxt  = '0;
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef ALU_RECV_SKID_EN
    ready_nxt = !skid_full_nxt;
`else
    if (accept) begin
      ready_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      fu_ready     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_wfid      <= '0;
      wb_opcode    <= '0;
      busy_wfid    <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      fu_ready     <= ready_nxt;
      wb_valid     <= valid_nxt;
      wb_wfid      <= wfid_nxt;
      wb_opcode    <= opcode_nxt;
      busy_wfid    <= busy_nxt;
      protocol_err <= err_nxt;
    end
  end

`ifdef ALU_RECV_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full   <= 1'b0;
      skid_wfid   <= '0;
      skid_opcode <= '0;
    end else begin
      skid_full   <= skid_full_nxt;
      skid_wfid   <= skid_wfid_nxt;
      skid_opcode <= skid_opcode_nxt;
    end
  end
`endif

endmodule

// File: doc/alu_issue_receiver.md
Name: alu_issue_receiver

Overview:
- Functional-unit-side endpoint of the ALU issue handshake.
- One instance sits in front of each SIMD/SIMF ALU, or the SALU/LSU. It drives that unit's ready line to the issue arbiter, captures the issued wavefront ID and opcode on a select pulse, and holds the unit busy for a fixed execution latency.
- It then presents the result to writeback with a valid/ack handshake before it can accept again.

Parameters:
- WF_ID_LENGTH, 6, width of wavefront ID.
- OPCODE_WIDTH, 32, width of the captured instruction/opcode word.
- LATENCY, 4, execution cycles from accept to writeback valid; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_select  in  1  select pulse from the issue arbiter for this unit.
- issue_wfid  in  WF_ID_LENGTH  wavefront ID issued with the select.
- issue_opcode  in  OPCODE_WIDTH  instruction word issued with the select.
- fu_ready  out  1  registered; unit can accept an issue this cycle.
- busy_wfid  out  WF_ID_LENGTH  wfid currently executing or awaiting writeback; 0 when idle.
- wb_valid  out  1  result pending for writeback.
- wb_wfid  out  WF_ID_LENGTH  wfid of the pending result.
- wb_opcode  out  OPCODE_WIDTH  opcode of the pending result.
- wb_ack  in  1  writeback consumed the result this cycle.
- protocol_err  out  1  sticky: select received while not ready.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, fu_ready=0, wb_valid=0, wb_wfid=0, wb_opcode=0, busy_wfid=0, protocol_err=0, counter=0.
  - Any in-flight instruction is dropped.
  - fu_ready rises at the first clk edge after rst deasserts.
- States: IDLE, EXEC, WB.
- IDLE:
  - fu_ready=1.
  - Accept = issue_select && fu_ready sampled at an edge.
  - On accept: capture wfid/opcode into wb_wfid/wb_opcode and busy_wfid, counter=LATENCY-1, state=EXEC, fu_ready=0 (same edge).
- EXEC:
  - Each edge: if counter==0, state=WB and wb_valid=1; else counter decrements.
  - wb_valid is therefore first visible after exactly LATENCY edges following the accept edge.
- WB:
  - wb_valid, wb_wfid and wb_opcode are held stable until wb_ack is sampled high.
  - On the ack edge: wb_valid=0, busy_wfid=0, state=IDLE, fu_ready=1.
  - wb_ack sampled while wb_valid=0 is ignored.
- Throughput without the optional feature: one issue per LATENCY+2 cycles minimum (wb_ack high in the first WB cycle).
- Protocol violation:
  - Condition: issue_select high at an edge with fu_ready low.
  - Select is ignored, no state change, protocol_err set to 1; it stays set until rst.
  - issue_select with fu_ready high is never an error.
- Counter width: 8 bits; no wrap possible within the legal LATENCY range.
- wb_wfid/wb_opcode are don't-care-stable in IDLE: they hold their last value and are only meaningful when wb_valid=1.

Optional Feature:
- Macro: ALU_RECV_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer (wfid+opcode+full flag), reset empty.
  - fu_ready = !skid_full in every state, so an issue can be accepted during EXEC or WB into the skid.
  - On the WB ack edge with skid full: skid contents are loaded into the capture registers, counter=LATENCY-1, state=EXEC, skid cleared, fu_ready=1.
  - Accept at IDLE with skid empty goes directly to EXEC, as without the macro.
  - A simultaneous accept and skid drain at the ack edge loads the skid into EXEC and the new issue into the skid; fu_ready stays 0.
  - Back-to-back period: LATENCY+1.
- Undefined: no skid; behaviour exactly as above.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> fu_ready=1 on the next edge; all other outputs 0.
- Single issue, LATENCY=4: select with wfid=6'h15, opcode=32'hDEAD_BEEF -> fu_ready 0 next cycle, busy_wfid=6'h15, wb_valid=1 after 4 edges with matching wfid/opcode; ack held 2 cycles late -> outputs stable until ack; fu_ready=1 after the ack edge.
- Protocol error: select during EXEC with wfid=6'h02 -> protocol_err=1 and stays 1; in-flight wfid 6'h15 completes unchanged.
- LATENCY=1 back-to-back with wb_ack tied high: continuous selects, wfids 1,2,3 -> accepted every 3 cycles; writebacks in order 1,2,3.
- Reset mid-WB: assert rst while wb_valid=1 -> wb_valid drops immediately (async); no writeback after release.
- ALU_RECV_SKID_EN, LATENCY=2: issue wfid 7 then wfid 8 one cycle later -> both accepted; fu_ready low after the second; wb of 7, then wb of 8 exactly 2 edges after the ack edge of 7.
